// File: rtl/smp_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : smp_mem_arbiter
// Brief    : NPORTS-way round-robin arbitrated single-word shared memory with
//            a fixed-latency, tag-echoing read-response pipeline.
// Revision : 1.0 - initial release
// ============================================================================
module smp_mem_arbiter #(
  parameter int NPORTS   = 2,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 256,
  parameter int TAG_W    = 2,
  parameter int READ_LAT = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NPORTS-1:0]          mem_rden,
  input  logic [NPORTS-1:0]          mem_wren,
  input  logic [NPORTS*ADDR_W-1:0]   req_addr,
  input  logic [NPORTS*DATA_W-1:0]   req_wdata,
  input  logic [NPORTS*TAG_W-1:0]    req_tag,
  output logic [NPORTS-1:0]          req_ready,
  output logic [NPORTS-1:0]          rsp_valid,
  output logic [NPORTS*DATA_W-1:0]   rsp_data,
  output logic [NPORTS*TAG_W-1:0]    rsp_tag
);

  localparam int c_ptr_w = (NPORTS > 1) ? $clog2(NPORTS) : 1;
  localparam int c_idx_w = $clog2(DEPTH);
  localparam int c_last  = READ_LAT - 1;

  logic [NPORTS-1:0]  w_req;
  logic [c_ptr_w-1:0] r_rr_ptr;
  logic [c_ptr_w-1:0] w_grant_idx;
  logic [c_ptr_w-1:0] w_cand;
  logic               w_grant_any;
  logic [ADDR_W-1:0]  w_sel_addr;
  logic [DATA_W-1:0]  w_sel_wdata;
  logic [TAG_W-1:0]   w_sel_tag;
  logic               w_sel_wr;
  logic               w_do_wr;
  logic               w_do_rd;
  logic [c_idx_w-1:0] w_index;
  logic               w_unused_addr;

  logic [DATA_W-1:0]  r_mem   [DEPTH];
  logic               r_pv    [READ_LAT];
  logic [c_ptr_w-1:0] r_pport [READ_LAT];
  logic [TAG_W-1:0]   r_ptag  [READ_LAT];
  logic [DATA_W-1:0]  r_pdata [READ_LAT];

  function automatic logic [c_ptr_w-1:0] f_wrap(input logic [c_ptr_w-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NPORTS) s = s - NPORTS;
    return c_ptr_w'(s);
  endfunction

  // Nothing is granted while reset is high, so no write can land on a reset edge.
  assign w_req = (mem_rden | mem_wren) & {NPORTS{~reset}};

  always_comb begin
    w_grant_any = 1'b0;
    w_grant_idx = '0;
    w_cand      = '0;
    for (int i = 0; i < NPORTS; i++) begin
      w_cand = f_wrap(r_rr_ptr, i);
      if (!w_grant_any && w_req[w_cand]) begin
        w_grant_any = 1'b1;
        w_grant_idx = w_cand;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (w_grant_any) req_ready[w_grant_idx] = 1'b1;
  end

  assign w_sel_addr    = req_addr[int'(w_grant_idx)*ADDR_W +: ADDR_W];
  assign w_sel_wdata   = req_wdata[int'(w_grant_idx)*DATA_W +: DATA_W];
  assign w_sel_tag     = req_tag[int'(w_grant_idx)*TAG_W +: TAG_W];
  assign w_sel_wr      = mem_wren[w_grant_idx];
  assign w_do_wr       = w_grant_any & w_sel_wr;
  assign w_do_rd       = w_grant_any & ~w_sel_wr;
  assign w_index       = w_sel_addr[c_idx_w+1:2];
  assign w_unused_addr = ^w_sel_addr;

  always_ff @(posedge clk) begin
    if (w_do_wr) r_mem[w_index] <= w_sel_wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rr_ptr <= '0;
    end else if (w_grant_any) begin
      r_rr_ptr <= f_wrap(w_grant_idx, 1);
    end
  end

  // Stage 0 captures the array word on the grant edge; the last stage is presented.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < READ_LAT; s++) begin
        r_pv[s]    <= 1'b0;
        r_pport[s] <= '0;
        r_ptag[s]  <= '0;
        r_pdata[s] <= '0;
      end
    end else begin
      r_pv[0]    <= w_do_rd;
      r_pport[0] <= w_grant_idx;
      r_ptag[0]  <= w_sel_tag;
      r_pdata[0] <= r_mem[w_index];
      for (int s = 1; s < READ_LAT; s++) begin
        r_pv[s]    <= r_pv[s-1];
        r_pport[s] <= r_pport[s-1];
        r_ptag[s]  <= r_ptag[s-1];
        r_pdata[s] <= r_pdata[s-1];
      end
    end
  end

  generate
    for (genvar p = 0; p < NPORTS; p++) begin : g_port
      logic              w_hit;
      logic [DATA_W-1:0] r_hold_data;
      logic [TAG_W-1:0]  r_hold_tag;

      assign w_hit = r_pv[c_last] && (r_pport[c_last] == c_ptr_w'(p));

      // Per-port copy keeps the last response visible once rsp_valid drops.
      always_ff @(posedge clk) begin
        if (reset) begin
          r_hold_data <= '0;
          r_hold_tag  <= '0;
        end else if (w_hit) begin
          r_hold_data <= r_pdata[c_last];
          r_hold_tag  <= r_ptag[c_last];
        end
      end

      assign rsp_valid[p]                 = w_hit;
      assign rsp_data[p*DATA_W +: DATA_W] = w_hit ? r_pdata[c_last] : r_hold_data;
      assign rsp_tag[p*TAG_W +: TAG_W]    = w_hit ? r_ptag[c_last] : r_hold_tag;
    end
  endgenerate

endmodule
`default_nettype wire
